// File: rtl/mem_bist_engine_if.sv
// Memory request/return bus between the BIST engine (master) and a single-port memory wrapper (slave).
// A request (mem_wrreq or mem_rdreq) is held until accepted. It is accepted on a rising clk edge where mem_ready=1.
// Read data comes back later on mem_q with mem_q_valid=1. Returns arrive in issue order and cannot be stalled.
interface mem_bist_engine_if #(
    parameter int WIDTH = 512,
    parameter int AW    = 10
);
    logic             mem_ready;
    logic [AW-1:0]    mem_address;
    logic             mem_wrreq;
    logic             mem_rdreq;
    logic [WIDTH-1:0] mem_d;
    logic [WIDTH-1:0] mem_q;
    logic             mem_q_valid;

    modport master (
        input  mem_ready, mem_q, mem_q_valid,
        output mem_address, mem_wrreq, mem_rdreq, mem_d
    );

    modport slave (
        output mem_ready, mem_q, mem_q_valid,
        input  mem_address, mem_wrreq, mem_rdreq, mem_d
    );
endinterface

// File: rtl/mem_bist_engine.sv
// Memory BIST engine: writes a pattern over addresses 0..RANGE-1, reads it back and scores the returns, for PASSES passes.
// Optional drain watchdog and timed_out output are enabled by defining MEM_BIST_TIMEOUT_EN.
module mem_bist_engine #(
    parameter int WIDTH   = 512,
    parameter int DEPTH   = 1024,
    parameter int RANGE   = 16,
    parameter int PASSES  = 1,
    parameter int SCORE_W = 16,
    parameter int TIMEOUT = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [1:0]         mode,
    mem_bist_engine_if.master  mem,
    output logic               busy,
    output logic               done,
    output logic               pass_ok,
    output logic [SCORE_W-1:0] correct_count,
    output logic [SCORE_W-1:0] wrong_count,
    output logic [AW-1:0]      first_err_addr,
    output logic               first_err_valid,
`ifdef MEM_BIST_TIMEOUT_EN
    output logic               timed_out,
`endif
    output logic [2:0]         dbg_state
);
    localparam int RB = $clog2(RANGE);
    localparam int CW = RB + 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    if (RANGE < 2 || RANGE > DEPTH || PASSES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mem_bist_engine: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [PW-1:0]   pass_q;
    logic [CW-1:0]   rcv_q;
    logic [1:0]      mode_q;
    logic            last_addr, last_pass, rcv_done, start_run, req_acc, score_en;
    logic [WIDTH-1:0] exp_word;

    // R = low address field replicated; checkerboard phase flips with address and pass parity.
    function automatic logic [WIDTH-1:0] pattern(input logic [RB-1:0] a, input logic p0,
                                                 input logic [1:0] m);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] cb;
        r = '0;
        for (int i = 0; i < WIDTH / RB; i++) r[i*RB +: RB] = a;
        for (int i = 0; i < WIDTH; i++) cb[i] = (i[0] == 1'b0) ^ (a[0] ^ p0);
        case (m)
            2'd0:    return r;
            2'd1:    return ~r;
            2'd2:    return cb;
            default: return {WIDTH{~p0}};
        endcase
    endfunction

    assign last_addr = (addr_q == AW'(RANGE - 1));
    assign last_pass = (pass_q == PW'(PASSES - 1));
    assign rcv_done  = (rcv_q == CW'(RANGE));
    assign start_run = start && (state_q == S_IDLE || state_q == S_DONE);
    assign req_acc   = mem.mem_ready && (state_q == S_WRITE || state_q == S_READ);
    assign score_en  = mem.mem_q_valid && (state_q == S_READ || state_q == S_DRAIN);
    assign exp_word  = pattern(rcv_q[RB-1:0], pass_q[0], mode_q);

`ifdef MEM_BIST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_q;
    logic          wd_expire;
    // Fires on the TIMEOUT-th consecutive silent DRAIN cycle.
    assign wd_expire = !mem.mem_q_valid && (wd_q == TW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d         = state_q;
        mem.mem_wrreq   = 1'b0;
        mem.mem_rdreq   = 1'b0;
        mem.mem_d       = '0;
        mem.mem_address = addr_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WRITE;
            S_WRITE: begin
                mem.mem_wrreq = 1'b1;
                mem.mem_d     = pattern(addr_q[RB-1:0], pass_q[0], mode_q);
                if (mem.mem_ready && last_addr) state_d = S_READ;
            end
            S_READ: begin
                mem.mem_rdreq = 1'b1;
                if (mem.mem_ready && last_addr) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (rcv_done) state_d = last_pass ? S_DONE : S_WRITE;
`ifdef MEM_BIST_TIMEOUT_EN
                else if (wd_expire) state_d = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            pass_q          <= '0;
            rcv_q           <= '0;
            mode_q          <= '0;
            correct_count   <= '0;
            wrong_count     <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
`ifdef MEM_BIST_TIMEOUT_EN
            wd_q            <= '0;
            timed_out       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (start_run) begin
                addr_q          <= '0;
                pass_q          <= '0;
                rcv_q           <= '0;
                mode_q          <= mode;
                correct_count   <= '0;
                wrong_count     <= '0;
                first_err_addr  <= '0;
                first_err_valid <= 1'b0;
`ifdef MEM_BIST_TIMEOUT_EN
                timed_out       <= 1'b0;
`endif
            end else begin
                if (req_acc) addr_q <= last_addr ? '0 : addr_q + 1'b1;
                if (score_en) begin
                    rcv_q <= rcv_q + 1'b1;
                    if (mem.mem_q == exp_word) begin
                        if (correct_count != '1) correct_count <= correct_count + 1'b1;
                    end else begin
                        if (wrong_count != '1) wrong_count <= wrong_count + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_addr  <= AW'(rcv_q[RB-1:0]);
                        end
                    end
                end
                // Next pass restarts the return count; rcv_done guarantees no return lands this cycle.
                if (state_q == S_DRAIN && state_d == S_WRITE) begin
                    pass_q <= pass_q + 1'b1;
                    rcv_q  <= '0;
                end
`ifdef MEM_BIST_TIMEOUT_EN
                if (state_q == S_DRAIN && !mem.mem_q_valid) wd_q <= wd_q + 1'b1;
                else wd_q <= '0;
                if (state_q == S_DRAIN && !rcv_done && wd_expire) timed_out <= 1'b1;
`endif
            end
        end
    end

    assign busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;
`ifdef MEM_BIST_TIMEOUT_EN
    assign pass_ok   = done && (wrong_count == '0) && !timed_out;
`else
    assign pass_ok   = done && (wrong_count == '0);
`endif
endmodule
